// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: FSM states, MIPS op codes and
// the iteration-counter sizing helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y = en ? -x : x. Used for operand magnitude
// and for the final sign fix of products, quotients and remainders.
module mdu_negate
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = x_i;
    if (en_i) y_o = ~x_i + {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit owning HI/LO; shift-add multiply and
// restoring divide. DIV/DIVU are present only when MDU_UNIT_DIV_EN is defined.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             mthi_e,
  input  logic             mtlo_e,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] low_q, low_d;   // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
  logic             neg_res_q, neg_res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_signed;
  logic             sign_a, sign_b;
  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_acc, step_low;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign sign_a    = is_signed & srca_e[WIDTH-1];
  assign sign_b    = is_signed & srcb_e[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.en_i(sign_a), .x_i(srca_e), .y_o(abs_a));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.en_i(sign_b), .x_i(srcb_e), .y_o(abs_b));

  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .en_i(neg_res_q),
    .x_i ({acc_q, low_q}),
    .y_o (prod_fix)
  );

`ifdef MDU_UNIT_DIV_EN
  logic             div_q, div_d;
  logic             neg_rem_q, neg_rem_d;
  logic             add_sub;
  logic             add_co;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept = start_e;

  mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (.en_i(neg_res_q), .x_i(low_q), .y_o(quo_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (.en_i(neg_rem_q), .x_i(acc_q), .y_o(rem_fix));

  // One WIDTH+1 adder: mult adds the multiplicand, div trial-subtracts the divisor.
  always_comb begin
    add_a   = {1'b0, acc_q};
    add_b   = {1'b0, opb_q};
    add_sub = 1'b0;
    if (div_q) begin
      add_a   = {acc_q, low_q[WIDTH-1]};
      add_sub = 1'b1;
    end
  end

  assign {add_co, add_sum} = {1'b0, add_a}
                           + {1'b0, (add_sub ? ~add_b : add_b)}
                           + {{(WIDTH+1){1'b0}}, add_sub};
`else
  assign accept  = start_e & ~op_e[1];
  assign add_a   = {1'b0, acc_q};
  assign add_b   = {1'b0, opb_q};
  assign add_sum = add_a + add_b;
`endif

  always_comb begin
    mul_sum  = low_q[0] ? add_sum : {1'b0, acc_q};
    step_acc = mul_sum[WIDTH:1];
    step_low = {mul_sum[0], low_q[WIDTH-1:1]};
`ifdef MDU_UNIT_DIV_EN
    // Carry out of the trial subtraction means remainder >= divisor.
    if (div_q) begin
      step_acc = add_co ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      step_low = {low_q[WIDTH-2:0], add_co};
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MDU_UNIT_DIV_EN
    div_d     = div_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_RUN;
          cnt_d     = CW'(WIDTH);
          acc_d     = '0;
          neg_res_d = sign_a ^ sign_b;
`ifdef MDU_UNIT_DIV_EN
          div_d     = op_e[1];
          neg_rem_d = sign_a;
          low_d     = op_e[1] ? abs_a : abs_b;
          opb_d     = op_e[1] ? abs_b : abs_a;
`else
          low_d     = abs_b;
          opb_d     = abs_a;
`endif
        end else begin
          if (mthi_e) hi_d = srca_e;
          if (mtlo_e) lo_d = srca_e;
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        low_d = step_low;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        {hi_d, lo_d} = prod_fix;
`ifdef MDU_UNIT_DIV_EN
        if (div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

`ifdef MDU_UNIT_DIV_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mult_done = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops checked
// against a plain-arithmetic model of HI/LO. Honours MDU_UNIT_DIV_EN.
module tb_mdu_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_e;
  logic [1:0]   op_e;
  logic [W-1:0] srca_e, srcb_e;
  logic         mthi_e, mtlo_e;
  logic [W-1:0] hi, lo;
  logic         mult_done;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi, exp_lo;

  mdu_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_e  (start_e),
    .op_e     (op_e),
    .srca_e   (srca_e),
    .srcb_e   (srcb_e),
    .mthi_e   (mthi_e),
    .mtlo_e   (mtlo_e),
    .hi       (hi),
    .lo       (lo),
    .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit accepted(input logic [1:0] op);
`ifdef MDU_UNIT_DIV_EN
    return 1'b1;
`else
    return !op[1];
`endif
  endfunction

  // {HI, LO} from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] q, m;
    sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!op[1]) return 64'(sa * sb);
    if (b == '0) begin
      q = (!op[0] && a[W-1]) ? 32'd1 : 32'hffff_ffff;
      return {a, q};
    end
    q = 32'(sa / sb);
    m = 32'(sa % sb);
    return {m, q};
  endfunction

  task automatic mt_write(input string tag, input bit wh, input bit wl, input logic [W-1:0] v);
    @(negedge clk);
    mthi_e = wh; mtlo_e = wl; srca_e = v;
    @(negedge clk);
    mthi_e = 1'b0; mtlo_e = 1'b0;
    if (wh) exp_hi = v;
    if (wl) exp_lo = v;
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  // Issue one op, optionally with mt* in the same cycle, and optionally poke
  // start/mt* once while busy (cycle intr_at). Checks busy length, hold, result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit mt_same, input int intr_at,
                        input bit intr_start, input bit intr_mt);
    int busy;
    bit held;
    logic [63:0] r;
    logic [W-1:0] pre_hi, pre_lo;
    pre_hi = exp_hi;
    pre_lo = exp_lo;
    @(negedge clk);
    start_e = 1'b1; op_e = op; srca_e = a; srcb_e = b;
    mthi_e = mt_same; mtlo_e = mt_same;
    @(posedge clk); #1;
    start_e = 1'b0; mthi_e = 1'b0; mtlo_e = 1'b0;
    srca_e = $urandom; srcb_e = $urandom; op_e = 2'($urandom);
    busy = 0;
    held = 1'b1;
    while (!mult_done && busy < 100) begin
      busy++;
      held = held && (hi === pre_hi) && (lo === pre_lo);
      if (busy == intr_at) begin
        start_e = intr_start; mthi_e = intr_mt; mtlo_e = intr_mt;
      end
      @(posedge clk); #1;
      start_e = 1'b0; mthi_e = 1'b0; mtlo_e = 1'b0;
    end
    if (accepted(op)) begin
      r = model(op, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    chk({tag, ".busy"}, 64'(busy), accepted(op) ? 64'(W + 1) : 64'd0);
    chk({tag, ".hold"}, 64'(held), 64'd1);
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, ".done"}, 64'(mult_done), 64'd1);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    reset = 1'b1; start_e = 1'b0; op_e = 2'b00;
    srca_e = '0; srcb_e = '0; mthi_e = 1'b0; mtlo_e = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.done", 64'(mult_done), 64'd1);
    reset = 1'b0;

    // mt* alone and together
    mt_write("mthi", 1'b1, 1'b0, 32'h1111_2222);
    mt_write("mtlo", 1'b0, 1'b1, 32'h3333_4444);
    mt_write("mtboth", 1'b1, 1'b1, 32'hdead_beef);

    // Reset ten cycles into a MULT aborts it and clears HI/LO
    @(negedge clk);
    start_e = 1'b1; op_e = 2'b00; srca_e = $urandom; srcb_e = $urandom;
    @(negedge clk);
    start_e = 1'b0;
    repeat (9) @(negedge clk);
    chk("rstmid.busy", 64'(mult_done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("rstmid.hi", 64'(hi), 64'd0);
    chk("rstmid.lo", 64'(lo), 64'd0);
    chk("rstmid.done", 64'(mult_done), 64'd1);
    run_op("multu3x5", 2'b01, 32'd3, 32'd5, 1'b0, 0, 1'b0, 1'b0);

    run_op("multu_max", 2'b01, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 0, 1'b0, 1'b0);
    run_op("mult_m7x3", 2'b00, 32'hffff_fff9, 32'd3, 1'b0, 0, 1'b0, 1'b0);
    run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0, 1'b0);

    // Divides (expected unchanged HI/LO and no busy time when the divider is absent)
    mt_write("predv", 1'b1, 1'b1, 32'h0bad_cafe);
    run_op("div_m7d2", 2'b10, 32'hffff_fff9, 32'd2, 1'b0, 0, 1'b0, 1'b0);
    run_op("divu_7d0", 2'b11, 32'd7, 32'd0, 1'b0, 0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hffff_ffff, 1'b0, 0, 1'b0, 1'b0);
    run_op("div_negd0", 2'b10, 32'hffff_fff0, 32'd0, 1'b0, 0, 1'b0, 1'b0);

    // Same-cycle mthi/mtlo lose to start; mt* and start while busy are ignored
    run_op("mt_vs_start", 2'b00, 32'h0000_1234, 32'h0010_0000, 1'b1, 0, 1'b0, 1'b0);
    run_op("mt_busy", 2'b01, 32'h0001_0001, 32'h0000_ffff, 1'b0, 7, 1'b0, 1'b1);
    run_op("start_busy", 2'b00, 32'hfedc_ba98, 32'h0123_4567, 1'b0, 10, 1'b1, 1'b0);
    run_op("start_fix", 2'b01, 32'h7fff_ffff, 32'h0000_0003, 1'b0, W + 1, 1'b1, 1'b1);
    run_op("b2b_a", 2'b01, 32'h0000_0010, 32'h0000_0020, 1'b0, 0, 1'b0, 1'b0);
    run_op("b2b_b", 2'b00, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(0, 9));
        1:       rb = '0;
        2:       rb = 32'hffff_ffff - 32'($urandom_range(0, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0)
        mt_write("rnd_mt", 1'($urandom), 1'($urandom), $urandom);
      run_op("rnd", rop, ra, rb, 1'b0, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
